// File: rtl/q_maze_pkg.sv
// Shared encodings for the grid-maze Q-learning episode controller.
package q_maze_pkg;

    // Action encodings as driven by the agent.
    localparam logic [1:0] ACT_N = 2'd0;
    localparam logic [1:0] ACT_E = 2'd1;
    localparam logic [1:0] ACT_S = 2'd2;
    localparam logic [1:0] ACT_W = 2'd3;

    // Bit positions inside the {W,S,E,N} wall nibble.
    localparam int unsigned WALL_N = 0;
    localparam int unsigned WALL_E = 1;
    localparam int unsigned WALL_S = 2;
    localparam int unsigned WALL_W = 3;

    // Episode controller FSM states.
    typedef enum logic [2:0] {
        IDLE,
        QREQ,
        MOVE,
        UPDATE,
        CHECK
    } ctrl_state_e;

    // Width of a cell index for a w x h grid.
    function automatic int unsigned state_width(input int unsigned w, input int unsigned h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/q_lfsr16.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing while en=1.
module q_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] value
);

    localparam logic [15:0] TAPS = 16'hB400;

    // Right-shifting Galois update; feedback from bit 0 into the tap positions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (en) begin
            value <= (value >> 1) ^ (value[0] ? TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/q_episode_ctrl.sv
// Episode controller for a GRID_W x GRID_H maze Q-learning agent:
// epsilon-greedy action pick, wall-aware move, internal reward, (s,a,s',r) handoff.
// Optional macro QCTRL_EPS_DECAY_EN: epsilon is captured once and decays by 1 per episode.
module q_episode_ctrl
    import q_maze_pkg::*;
#(
    parameter int unsigned  GRID_W       = 4,
    parameter int unsigned  GRID_H       = 4,
    parameter int unsigned  RW           = 16,
    parameter int unsigned  EPS_W        = 8,
    parameter int unsigned  MAX_STEPS    = 64,
    parameter int           GOAL_REWARD  = 100,
    parameter int           WALL_PENALTY = 10,
    parameter int           STEP_PENALTY = 1,
    parameter logic [15:0]  LFSR_SEED    = 16'hACE1,
    localparam int unsigned SW           = state_width(GRID_W, GRID_H),
    localparam int unsigned SCW          = $clog2(MAX_STEPS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [EPS_W-1:0]     epsilon,
    input  logic [SW-1:0]        start_state,
    input  logic [SW-1:0]        goal_state,
    output logic                 q_req,
    output logic [SW-1:0]        q_state,
    input  logic                 q_valid,
    input  logic [1:0]           q_best_action,
    output logic [SW-1:0]        map_state,
    input  logic [3:0]           map_walls,
    output logic                 upd_valid,
    input  logic                 upd_ready,
    output logic [SW-1:0]        upd_state,
    output logic [SW-1:0]        upd_next_state,
    output logic [1:0]           upd_action,
    output logic signed [RW-1:0] upd_reward,
    output logic                 episode_done,
    output logic [SCW-1:0]       step_count,
    output logic [15:0]          episode_count,
    output logic                 busy
);

    localparam logic signed [RW-1:0] R_GOAL = RW'(GOAL_REWARD);
    localparam logic signed [RW-1:0] R_WALL = RW'(-WALL_PENALTY);
    localparam logic signed [RW-1:0] R_STEP = RW'(-STEP_PENALTY);

    ctrl_state_e          state;
    ctrl_state_e          state_nx;
    logic [SW-1:0]        cur_state;
    logic                 fresh;
    logic [15:0]          lfsr;
    logic [EPS_W-1:0]     eps_cmp;
    logic                 explore_c;
    logic [1:0]           act_sel_c;
    logic [SW-1:0]        row_c;
    logic [SW-1:0]        col_c;
    logic [SW-1:0]        target_c;
    logic                 blocked_c;
    logic signed [RW-1:0] reward_c;
    logic [SCW-1:0]       steps_c;
    logic                 done_c;
    logic                 unused_lfsr_c;

    q_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .value (lfsr)
    );

    assign unused_lfsr_c = ^lfsr[15:EPS_W+2];
    assign q_state       = cur_state;
    assign map_state     = cur_state;

`ifdef QCTRL_EPS_DECAY_EN
    logic [EPS_W-1:0] eps_reg;
    logic             eps_loaded;

    // Capture epsilon on the first run after reset, then decay once per finished episode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eps_reg    <= '0;
            eps_loaded <= 1'b0;
        end else if (state == IDLE && en && !eps_loaded) begin
            eps_reg    <= epsilon;
            eps_loaded <= 1'b1;
        end else if (state == CHECK && done_c && eps_reg != '0) begin
            eps_reg <= eps_reg - EPS_W'(1);
        end
    end

    assign eps_cmp = eps_reg;
`else
    assign eps_cmp = epsilon;
`endif

    // Epsilon-greedy pick: explore with two LFSR bits when the random field is below epsilon.
    assign explore_c = (lfsr[EPS_W-1:0] < eps_cmp);
    assign act_sel_c = explore_c ? lfsr[EPS_W+1:EPS_W] : q_best_action;

    assign row_c   = cur_state / SW'(GRID_W);
    assign col_c   = cur_state % SW'(GRID_W);
    assign steps_c = step_count + SCW'(1);
    assign done_c  = (upd_next_state == goal_state) || (steps_c == SCW'(MAX_STEPS));

    // Target cell, blocking (grid edge or wall) and reward for the latched action.
    always_comb begin
        target_c  = cur_state;
        blocked_c = 1'b0;
        case (upd_action)
            ACT_N: begin
                blocked_c = (row_c == '0) || map_walls[WALL_N];
                target_c  = cur_state - SW'(GRID_W);
            end
            ACT_E: begin
                blocked_c = (col_c == SW'(GRID_W - 1)) || map_walls[WALL_E];
                target_c  = cur_state + SW'(1);
            end
            ACT_S: begin
                blocked_c = (row_c == SW'(GRID_H - 1)) || map_walls[WALL_S];
                target_c  = cur_state + SW'(GRID_W);
            end
            ACT_W: begin
                blocked_c = (col_c == '0) || map_walls[WALL_W];
                target_c  = cur_state - SW'(1);
            end
            default: ;
        endcase
        if (blocked_c) begin
            target_c = cur_state;
            reward_c = R_WALL;
        end else if (target_c == goal_state) begin
            reward_c = R_GOAL;
        end else begin
            reward_c = R_STEP;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = QREQ;
            QREQ:    if (q_valid) state_nx = MOVE;
            MOVE:    state_nx = UPDATE;
            UPDATE:  if (upd_ready) state_nx = CHECK;
            CHECK:   state_nx = en ? QREQ : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath, counters and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state      <= '0;
            fresh          <= 1'b1;
            q_req          <= 1'b0;
            upd_valid      <= 1'b0;
            busy           <= 1'b0;
            episode_done   <= 1'b0;
            upd_state      <= '0;
            upd_next_state <= '0;
            upd_action     <= '0;
            upd_reward     <= '0;
            step_count     <= '0;
            episode_count  <= '0;
        end else begin
            q_req        <= (state_nx == QREQ);
            upd_valid    <= (state_nx == UPDATE);
            busy         <= (state_nx != IDLE);
            episode_done <= (state == CHECK) && done_c;
            case (state)
                IDLE: begin
                    if (en && fresh) begin
                        cur_state <= start_state;
                        fresh     <= 1'b0;
                    end
                end
                QREQ: begin
                    if (q_valid) upd_action <= act_sel_c;
                end
                MOVE: begin
                    upd_state      <= cur_state;
                    upd_next_state <= target_c;
                    upd_reward     <= reward_c;
                end
                CHECK: begin
                    if (done_c) begin
                        step_count    <= '0;
                        episode_count <= episode_count + 16'd1;
                        cur_state     <= start_state;
                        fresh         <= !en;
                    end else begin
                        step_count <= steps_c;
                        cur_state  <= upd_next_state;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_q_episode_ctrl.sv
// Self-checking bench for q_episode_ctrl: directed table, hand-written corner
// sequences and randomized steps against a grid-level reference model.
module tb_q_episode_ctrl;

    localparam int GRID_W       = 4;
    localparam int GRID_H       = 4;
    localparam int CELLS        = GRID_W * GRID_H;
    localparam int SW           = $clog2(CELLS);
    localparam int MAX_STEPS    = 8;
    localparam int SCW          = $clog2(MAX_STEPS + 1);
    localparam int RW           = 16;
    localparam int EPS_W        = 8;
    localparam int GOAL_REWARD  = 100;
    localparam int WALL_PENALTY = 10;
    localparam int STEP_PENALTY = 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic [EPS_W-1:0]     epsilon = '0;
    logic [SW-1:0]        start_state = '0;
    logic [SW-1:0]        goal_state = SW'(15);
    logic                 q_req;
    logic [SW-1:0]        q_state;
    logic                 q_valid = 1'b0;
    logic [1:0]           q_best_action = 2'd0;
    logic [SW-1:0]        map_state;
    logic [3:0]           map_walls;
    logic                 upd_valid;
    logic                 upd_ready = 1'b0;
    logic [SW-1:0]        upd_state;
    logic [SW-1:0]        upd_next_state;
    logic [1:0]           upd_action;
    logic signed [RW-1:0] upd_reward;
    logic                 episode_done;
    logic [SCW-1:0]       step_count;
    logic [15:0]          episode_count;
    logic                 busy;

    logic [3:0] wall_mem [CELLS];
    assign map_walls = wall_mem[map_state];

    q_episode_ctrl #(
        .GRID_W       (GRID_W),
        .GRID_H       (GRID_H),
        .RW           (RW),
        .EPS_W        (EPS_W),
        .MAX_STEPS    (MAX_STEPS),
        .GOAL_REWARD  (GOAL_REWARD),
        .WALL_PENALTY (WALL_PENALTY),
        .STEP_PENALTY (STEP_PENALTY),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .epsilon        (epsilon),
        .start_state    (start_state),
        .goal_state     (goal_state),
        .q_req          (q_req),
        .q_state        (q_state),
        .q_valid        (q_valid),
        .q_best_action  (q_best_action),
        .map_state      (map_state),
        .map_walls      (map_walls),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_state      (upd_state),
        .upd_next_state (upd_next_state),
        .upd_action     (upd_action),
        .upd_reward     (upd_reward),
        .episode_done   (episode_done),
        .step_count     (step_count),
        .episode_count  (episode_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [15:0] m_lfsr;
    int          m_cur   = 0;
    int          m_steps = 0;
    int          m_ep    = 0;
    bit          m_fresh = 1'b1;
`ifdef QCTRL_EPS_DECAY_EN
    int          m_eps        = 0;
    bit          m_eps_loaded = 1'b0;
`endif

    // One shift of the x^16+x^14+x^13+x^11+1 Galois register.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] poly;
        poly = 16'b1011_0100_0000_0000;
        return v[0] ? ((v >> 1) ^ poly) : (v >> 1);
    endfunction

    // Random source runs every enabled cycle, independent of the step flow.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else if (en) m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic int eps_model();
`ifdef QCTRL_EPS_DECAY_EN
        return m_eps;
`else
        return int'(epsilon);
`endif
    endfunction

    // Grid move by row/column arithmetic.
    function automatic void model_move(input int cur, input int act, input logic [3:0] walls,
                                       input int goal, output int ns, output int r);
        int row, col, tr, tc;
        bit blocked;
        row = cur / GRID_W;
        col = cur % GRID_W;
        tr  = row;
        tc  = col;
        case (act)
            0:       tr = row - 1;
            1:       tc = col + 1;
            2:       tr = row + 1;
            default: tc = col - 1;
        endcase
        blocked = (tr < 0) || (tr >= GRID_H) || (tc < 0) || (tc >= GRID_W) || walls[act];
        if (blocked) begin
            ns = cur;
            r  = -WALL_PENALTY;
        end else begin
            ns = tr * GRID_W + tc;
            r  = (ns == goal) ? GOAL_REWARD : -STEP_PENALTY;
        end
    endfunction

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else n_pass++;
    endtask

    // Raise or drop run enable; only raised while the controller is idle.
    task automatic set_en(input logic v);
        if (v && m_fresh) begin
            m_cur   = int'(start_state);
            m_fresh = 1'b0;
        end
`ifdef QCTRL_EPS_DECAY_EN
        if (v && !m_eps_loaded) begin
            m_eps        = int'(epsilon);
            m_eps_loaded = 1'b1;
        end
`endif
        en = v;
    endtask

    // Drive one full step and check every observable against the model.
    task automatic do_step(input logic [1:0] greedy, input int rdy_delay, input bit drop_en,
                           output int o_s, output int o_a, output int o_ns, output int o_r);
        int n, ea, ens, er, steps;
        bit explore, done;
        n = 0;
        while (q_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("q_req", q_req, 1);
        check("q_state", q_state, m_cur);
        explore = (int'(m_lfsr[EPS_W-1:0]) < eps_model());
        ea = explore ? int'(m_lfsr[EPS_W+1:EPS_W]) : int'(greedy);
        q_best_action = greedy;
        q_valid = 1'b1;
        @(negedge clk);
        q_valid = 1'b0;
        q_best_action = 2'($urandom);
        model_move(m_cur, ea, wall_mem[m_cur], int'(goal_state), ens, er);
        n = 0;
        while (upd_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        o_s  = int'(upd_state);
        o_a  = int'(upd_action);
        o_ns = int'(upd_next_state);
        o_r  = int'(upd_reward);
        if (drop_en) en = 1'b0;
        for (int i = 0; i <= rdy_delay; i++) begin
            check("upd_valid", upd_valid, 1);
            check("upd_state", upd_state, m_cur);
            check("upd_action", upd_action, ea);
            check("upd_next_state", upd_next_state, ens);
            check("upd_reward", upd_reward, er);
            if (i == rdy_delay) upd_ready = 1'b1;
            @(negedge clk);
        end
        upd_ready = 1'b0;
        check("upd_valid_after_xfer", upd_valid, 0);
        @(negedge clk);
        steps = m_steps + 1;
        done  = (ens == int'(goal_state)) || (steps == MAX_STEPS);
        if (done) begin
            m_steps = 0;
            m_ep    = (m_ep + 1) % 65536;
            m_cur   = int'(start_state);
            m_fresh = !en;
`ifdef QCTRL_EPS_DECAY_EN
            if (m_eps > 0) m_eps--;
`endif
        end else begin
            m_steps = steps;
            m_cur   = ens;
        end
        check("episode_done", episode_done, done);
        check("step_count", step_count, m_steps);
        check("episode_count", episode_count, m_ep);
        check("busy", busy, en);
    endtask

    task automatic run_random(input int n, input bit rand_greedy, input bit rand_eps);
        int s, a, ns, r;
        bit drop;
        logic [1:0] g;
        for (int i = 0; i < n; i++) begin
            if (i % 25 == 0) begin
                for (int c = 0; c < CELLS; c++) wall_mem[c] = 4'($urandom);
            end
            g = rand_greedy ? 2'($urandom) : 2'd0;
            if (rand_eps) epsilon = EPS_W'($urandom);
            drop = ($urandom_range(0, 9) == 0);
            do_step(g, $urandom_range(0, 3), drop, s, a, ns, r);
            if (drop) begin
                repeat ($urandom_range(1, 3)) begin
                    check("idle_busy", busy, 0);
                    check("idle_q_req", q_req, 0);
                    @(negedge clk);
                end
                set_en(1'b1);
            end
        end
    endtask

    typedef struct {
        logic [1:0] greedy;
        logic [3:0] w5;
        int         start;
        int         es, ea, ens, er;
        int         edone, esteps, eep;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int s, a, ns, r, n;

        tbl[0]  = '{2'd1, 4'd0, 0,  0, 1,  1,  -1, 0, 1, 0};
        tbl[1]  = '{2'd1, 4'd0, 0,  1, 1,  2,  -1, 0, 2, 0};
        tbl[2]  = '{2'd1, 4'd0, 0,  2, 1,  3,  -1, 0, 3, 0};
        tbl[3]  = '{2'd2, 4'd0, 0,  3, 2,  7,  -1, 0, 4, 0};
        tbl[4]  = '{2'd2, 4'd0, 0,  7, 2, 11,  -1, 0, 5, 0};
        tbl[5]  = '{2'd2, 4'd0, 0, 11, 2, 15, 100, 1, 0, 1};
        tbl[6]  = '{2'd0, 4'd0, 0,  0, 0,  0, -10, 0, 1, 1};
        for (int k = 7; k <= 13; k++)
            tbl[k] = '{2'd3, 4'd0, (k == 13) ? 5 : 0, 0, 3, 0, -10,
                       (k == 13) ? 1 : 0, (k == 13) ? 0 : k - 5, (k == 13) ? 2 : 1};
        tbl[14] = '{2'd1, 4'b0010, 5, 5, 1, 5, -10, 0, 1, 2};
        tbl[15] = '{2'd1, 4'b0000, 5, 5, 1, 6,  -1, 0, 2, 2};

        for (int c = 0; c < CELLS; c++) wall_mem[c] = 4'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_q_req", q_req, 0);
        check("rst_q_state", q_state, 0);
        check("rst_map_state", map_state, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_upd_state", upd_state, 0);
        check("rst_upd_next", upd_next_state, 0);
        check("rst_upd_action", upd_action, 0);
        check("rst_upd_reward", upd_reward, 0);
        check("rst_episode_done", episode_done, 0);
        check("rst_step_count", step_count, 0);
        check("rst_episode_count", episode_count, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy_after_rst", busy, 0);
        set_en(1'b1);

        // Directed vectors: goal path, out-of-bounds, step limit, wall vs open.
        for (int k = 0; k < 16; k++) begin
            wall_mem[5] = tbl[k].w5;
            start_state = SW'(tbl[k].start);
            do_step(tbl[k].greedy, 0, 1'b0, s, a, ns, r);
            check("tbl_s", s, tbl[k].es);
            check("tbl_a", a, tbl[k].ea);
            check("tbl_ns", ns, tbl[k].ens);
            check("tbl_r", r, tbl[k].er);
            check("tbl_done", episode_done, tbl[k].edone);
            check("tbl_steps", step_count, tbl[k].esteps);
            check("tbl_episodes", episode_count, tbl[k].eep);
        end

        // Backpressure for 5 cycles with en dropped during the wait.
        do_step(2'd2, 5, 1'b1, s, a, ns, r);
        check("bp_ns", ns, 10);
        repeat (3) begin
            @(negedge clk);
            check("bp_idle_busy", busy, 0);
            check("bp_idle_q_req", q_req, 0);
        end
        set_en(1'b1);
        do_step(2'd1, 0, 1'b0, s, a, ns, r);
        check("resume_s", s, 10);
        do_step(2'd2, 1, 1'b0, s, a, ns, r);
        check("goal_r", r, 100);
        check("goal_episodes", episode_count, 3);
        @(negedge clk);
        check("done_pulse_width", episode_done, 0);

        // Full exploration, greedy fixed at N.
        start_state = '0;
        epsilon = '1;
        run_random(200, 1'b0, 1'b0);
        // Mixed greedy actions and epsilon values.
        run_random(60, 1'b1, 1'b1);

        // Reset asserted while an update is pending.
        n = 0;
        while (q_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        q_valid = 1'b1;
        @(negedge clk);
        q_valid = 1'b0;
        n = 0;
        while (upd_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("pre_rst_upd_valid", upd_valid, 1);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        check("mid_rst_upd_valid", upd_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_q_req", q_req, 0);
        check("mid_rst_step_count", step_count, 0);
        check("mid_rst_episode_count", episode_count, 0);
        m_cur   = 0;
        m_steps = 0;
        m_ep    = 0;
        m_fresh = 1'b1;
`ifdef QCTRL_EPS_DECAY_EN
        m_eps_loaded = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_upd_valid", upd_valid, 0);
        check("post_rst_busy", busy, 0);
        epsilon = '1;
        set_en(1'b1);
        run_random(20, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
